// File: rtl/saturate_arbiter_if.sv
// Handshake bundle between N accumulator sources, the shared saturation stage
// and the downstream result consumer.
interface saturate_arbiter_if #(
  parameter int N    = 4,
  parameter int ARGW = 24,
  parameter int RESW = 16
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]      arg_valid;
  logic [N-1:0]      arg_ready;
  logic [N*ARGW-1:0] arg_data;
  logic              res_valid;
  logic              res_ready;
  logic [RESW-1:0]   res_data;
  logic [IDW-1:0]    res_id;
  logic              res_sat;

  // master: the sources plus the result consumer
  modport master (
    output arg_valid, arg_data, res_ready,
    input  arg_ready, res_valid, res_data, res_id, res_sat
  );

  // slave: the arbiter/saturation stage
  modport slave (
    input  arg_valid, arg_data, res_ready,
    output arg_ready, res_valid, res_data, res_id, res_sat
  );
endinterface

// File: rtl/saturate_arbiter.sv
// Round-robin arbiter feeding one signed saturation stage; the clamped result is
// registered with its source ID and a clamp flag on a valid/ready stream.
module saturate_arbiter #(
  parameter int N    = 4,
  parameter int ARGW = 24,
  parameter int RESW = 16
) (
  input  logic                clk,
  input  logic                rst,
  saturate_arbiter_if.slave   bus,
  input  logic                sat_clear,
  output logic [N-1:0]        sat_flags
);
  localparam int IDW = $clog2(N);
  localparam logic [RESW-1:0] RES_MAX = {1'b0, {(RESW-1){1'b1}}};
  localparam logic [RESW-1:0] RES_MIN = {1'b1, {(RESW-1){1'b0}}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  ptr_reg, ptr_next;
  logic [RESW-1:0] res_data_reg;
  logic [IDW-1:0]  res_id_reg;
  logic            res_sat_reg;
  logic [N-1:0]    sat_flags_reg, sat_flags_next;

  logic [ARGW-1:0] arg_word [N];
  logic            can_accept;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  rr_pos;
  logic [N-1:0]    grant_vec;
  logic [ARGW-1:0] sel_arg;
  logic            in_range;
  logic [RESW-1:0] sat_data;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign arg_word[gi] = bus.arg_data[gi*ARGW +: ARGW];
  end

  // Reset also blocks grants so no source believes it transferred in that cycle.
  assign can_accept = ((state_reg == EMPTY) || bus.res_ready) && !rst;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_pos    = '0;
    grant_vec = '0;
    if (can_accept) begin
      for (int off = 0; off < N; off++) begin
        rr_pos = IDW'((int'(ptr_reg) + off) % N);
        if (!grant_any && bus.arg_valid[rr_pos]) begin
          grant_any = 1'b1;
          grant_idx = rr_pos;
        end
      end
    end
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign ptr_next = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;

  // In range exactly when every bit above the result sign bit matches the sign.
  assign sel_arg  = arg_word[grant_idx];
  assign in_range = (&sel_arg[ARGW-1:RESW-1]) || !(|sel_arg[ARGW-1:RESW-1]);
  assign sat_data = in_range ? sel_arg[RESW-1:0]
                             : (sel_arg[ARGW-1] ? RES_MIN : RES_MAX);

  // A clamp landing with sat_clear survives the clear.
  for (genvar gi = 0; gi < N; gi++) begin : g_flags
    assign sat_flags_next[gi] = (sat_flags_reg[gi] && !sat_clear) ||
                                (grant_vec[gi] && !in_range);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (grant_any) state_next = FULL;
      end
      FULL: begin
        if (bus.res_ready && !grant_any) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      ptr_reg       <= '0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
      res_sat_reg   <= 1'b0;
      sat_flags_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sat_flags_reg <= sat_flags_next;
      if (grant_any) begin
        ptr_reg      <= ptr_next;
        res_data_reg <= sat_data;
        res_id_reg   <= grant_idx;
        res_sat_reg  <= !in_range;
      end
    end
  end

  assign bus.arg_ready = grant_vec;
  assign bus.res_valid = (state_reg == FULL);
  assign bus.res_data  = res_data_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.res_sat   = res_sat_reg;
  assign sat_flags     = sat_flags_reg;
endmodule

// File: tb/tb_saturate_arbiter.sv
// Scoreboard bench for saturate_arbiter: per-source request queue, cycle model of
// grant/occupancy/flags, expected results queued at grant and compared at output.
module tb_saturate_arbiter;
  localparam int N    = 4;
  localparam int ARGW = 24;
  localparam int RESW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         sat_clear;
  logic [N-1:0] sat_flags;

  always #5 clk = ~clk;

  saturate_arbiter_if #(.N(N), .ARGW(ARGW), .RESW(RESW)) bus();

  saturate_arbiter #(.N(N), .ARGW(ARGW), .RESW(RESW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_clear (sat_clear),
    .sat_flags (sat_flags)
  );

  typedef struct packed {logic [1:0] id; logic [15:0] data; logic sat;} res_t;
  typedef struct packed {logic [1:0] src; logic [23:0] val;} req_t;

  res_t       exp_q[$];
  req_t       src_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic       m_full;
  logic [1:0] m_ptr;
  logic [3:0] m_flags;
  logic       res_ready_drv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic res_t sat_model(input logic [1:0] id, input logic [23:0] a);
    res_t r;
    int   sa;
    sa   = $signed(a);
    r.id = id;
    if (sa > 32767) begin
      r.data = 16'h7fff; r.sat = 1'b1;
    end else if (sa < -32768) begin
      r.data = 16'h8000; r.sat = 1'b1;
    end else begin
      r.data = a[15:0];  r.sat = 1'b0;
    end
    return r;
  endfunction

  function automatic int head(input int s);
    for (int i = 0; i < src_q.size(); i++)
      if (int'(src_q[i].src) == s) return i;
    return -1;
  endfunction

  task automatic drive();
    int h;
    for (int i = 0; i < N; i++) begin
      h = head(i);
      bus.arg_valid[i] = (h >= 0);
      bus.arg_data[i*ARGW +: ARGW] = (h >= 0) ? src_q[h].val : 24'h0;
    end
    bus.res_ready = res_ready_drv;
  endtask

  task automatic enq(input int s, input logic [23:0] v);
    req_t r;
    r.src = 2'(s);
    r.val = v;
    src_q.push_back(r);
    drive();
  endtask

  // One clock: check and advance the model at negedge, re-drive inputs after posedge.
  task automatic step();
    int         g;
    int         h;
    logic [3:0] exp_ready;
    logic [3:0] set;
    res_t       e;
    @(negedge clk);
    g = -1;
    exp_ready = '0;
    set = '0;
    if (rst) begin
      exp_q.delete();
      src_q.delete();
      m_full = 1'b0; m_ptr = '0; m_flags = '0;
    end else begin
      chk("res_valid", bus.res_valid, m_full);
      if (m_full && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("res_data", bus.res_data, e.data);
        chk("res_id", bus.res_id, e.id);
        chk("res_sat", bus.res_sat, e.sat);
        if (res_ready_drv) begin
          $display("txn id=%0d data=%h sat=%0d", e.id, e.data, e.sat);
          void'(exp_q.pop_front());
        end
      end
      chk("sat_flags", sat_flags, m_flags);
      if (!m_full || res_ready_drv)
        for (int off = 0; off < N; off++)
          if (g < 0 && bus.arg_valid[(int'(m_ptr) + off) % N]) g = (int'(m_ptr) + off) % N;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("arg_ready", bus.arg_ready, exp_ready);
      if (g >= 0) begin
        h = head(g);
        e = sat_model(2'(g), src_q[h].val);
        exp_q.push_back(e);
        if (e.sat) set[g] = 1'b1;
        m_ptr = 2'((g + 1) % N);
        src_q.delete(h);
      end
      m_flags = (sat_clear ? 4'b0000 : m_flags) | set;
      m_full  = (g >= 0) || (m_full && !res_ready_drv);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((src_q.size() > 0 || m_full) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) chk("drain_timeout", 32'(n), 0);
  endtask

  task automatic run_suite();
    int n;
    // T1: in-range values pass straight through
    res_ready_drv = 1'b1;
    enq(0, 24'h0000ff); enq(0, 24'hffff00);
    drain(n);
    // T2: clamps and exact boundaries
    enq(2, 24'h7fffff); drain(n);
    chk("t2_flags_a", sat_flags, 4'b0100);
    enq(1, 24'h800000); drain(n);
    chk("t2_flags_b", sat_flags, 4'b0110);
    enq(3, 24'h007fff); enq(3, 24'hff8000); drain(n);
    chk("t2_flags_c", sat_flags, 4'b0110);
    // T3: all sources busy, then src1 runs dry; one grant per cycle throughout
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < N; s++) enq(s, 24'($urandom));
    for (int r = 0; r < 3; r++) begin
      enq(0, 24'($urandom)); enq(2, 24'($urandom)); enq(3, 24'($urandom));
    end
    drain(n);
    chk("t3_cycles", 32'(n), 22);
    // T4: backpressure while FULL
    res_ready_drv = 1'b0;
    enq(0, 24'h001234); enq(1, 24'hfff000);
    step();
    for (int i = 0; i < 3; i++) step();
    res_ready_drv = 1'b1;
    drive();
    drain(n);
    // T5: sat_clear racing a new clamp on src1
    sat_clear = 1'b1; step(); sat_clear = 1'b0;
    enq(2, 24'h7fffff); enq(1, 24'h800000); drain(n);
    chk("t5_flags_pre", sat_flags, 4'b0110);
    enq(1, 24'h900000);
    sat_clear = 1'b1; step(); sat_clear = 1'b0;
    chk("t5_flags_race", sat_flags, 4'b0010);
    drain(n);
    sat_clear = 1'b1; step(); sat_clear = 1'b0;
    chk("t5_flags_clear", sat_flags, 4'b0000);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_res_id"}, bus.res_id, 0);
    chk({tag, "_res_sat"}, bus.res_sat, 0);
    chk({tag, "_sat_flags"}, sat_flags, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; sat_clear = 1'b0; res_ready_drv = 1'b1;
    m_full = 1'b0; m_ptr = '0; m_flags = '0;
    bus.arg_valid = '0; bus.arg_data = '0; bus.res_ready = 1'b1;
    step();
    rst = 1'b0;
    reset_checks("reset");
    run_suite();
    // T6: reset while holding a result from src2
    enq(1, 24'h800000); drain(n);
    res_ready_drv = 1'b0;
    enq(2, 24'h123456);
    step();
    chk("t6_held_id", bus.res_id, 2);
    rst = 1'b1; step(); rst = 1'b0;
    reset_checks("t6");
    res_ready_drv = 1'b1;
    for (int s = 0; s < N; s++) enq(s, 24'(s * 16));
    step();
    chk("t6_first_id", bus.res_id, 0);
    drain(n);
    run_suite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
